// File: rtl/ram_moram_dp.sv
// Dual-port motion-object RAM with a hardware clear engine and selectable read-during-write policy.
// Optional per-byte write enables on port 1 are enabled by defining MORAM_BYTE_EN.
module ram_moram_dp #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                RDW_MODE  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   p1_a,
    input  logic [DATA_W-1:0]   p1_di,
    input  logic                p1_r,
    input  logic                p1_w,
`ifdef MORAM_BYTE_EN
    input  logic [DATA_W/8-1:0] p1_be,
`endif
    output logic [DATA_W-1:0]   p1_do,
    input  logic [ADDR_W-1:0]   p2_a,
    input  logic                p2_r,
    output logic [DATA_W-1:0]   p2_do,
    input  logic                clr_req,
    output logic                busy
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                busy_q;
    logic [DATA_W-1:0]   p1_do_q, p2_do_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_a;
    logic [DATA_W-1:0]   wr_data;
    logic [NBYTES-1:0]   wr_be;
    logic [NBYTES-1:0]   p1_be_int;
    logic [DATA_W-1:0]   rd1, rd2;

`ifdef MORAM_BYTE_EN
    assign p1_be_int = p1_be;
`else
    assign p1_be_int = '1;
`endif

    function automatic logic [DATA_W-1:0] mergeBytes(input logic [DATA_W-1:0] oldWord,
                                                     input logic [DATA_W-1:0] newWord,
                                                     input logic [NBYTES-1:0] be);
        logic [DATA_W-1:0] res;
        res = oldWord;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) res[i*8 +: 8] = newWord[i*8 +: 8];
        end
        return res;
    endfunction

    // The clear engine owns the single write path while sweeping; port-1 writes are dropped then.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_a    = p1_a;
        wr_data = p1_di;
        wr_be   = p1_be_int;
        case (state_q)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_a    = cnt_q;
                wr_data = CLEAR_VAL;
                wr_be   = '1;
                if (clr_req) begin
                    cnt_d = '0;
                end else if (cnt_q == '1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                wr_en = p1_w;
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == CLEAR);
        end
    end

    // Array has no reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) mem[wr_a][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rd1 = mem[p1_a];
        rd2 = mem[p2_a];
        if (RDW_MODE == 1 && wr_en) begin
            if (wr_a == p1_a) rd1 = mergeBytes(mem[p1_a], wr_data, wr_be);
            if (wr_a == p2_a) rd2 = mergeBytes(mem[p2_a], wr_data, wr_be);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_do_q <= '0;
            p2_do_q <= '0;
        end else begin
            if (p1_r) p1_do_q <= rd1;
            if (p2_r) p2_do_q <= rd2;
        end
    end

    assign p1_do = p1_do_q;
    assign p2_do = p2_do_q;
    assign busy  = busy_q;

endmodule
